// File: rtl/switch_peripheral.sv
// Memory-mapped switch/button input peripheral: two-flop synchronizer,
// per-pin debounce, sticky W1C rise/fall events and a level interrupt.
module switch_peripheral #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en_i,
    input  logic             wr_en_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [WIDTH-1:0] sw_i,
    output logic             irq_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta_q, sync_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_set, fall_set;
    logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0] ien_r_q, ien_r_d, ien_f_q, ien_f_d;
    logic [WIDTH-1:0] clr_r, clr_f;
    logic [31:0]      data_q, data_d;
    logic [31:0]      event_w, ien_w;
    logic             wr_evt, wr_ien;
    logic             unused_w;

    assign unused_w = ^{addr_i[31:4], addr_i[1:0], data_i};

    // A level is accepted only after the counter saturates while sync differs.
    always_comb begin
        stable_d = stable_q;
        rise_set = '0;
        fall_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync_q[i];
                    rise_set[i] = sync_q[i];
                    fall_set[i] = ~sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign wr_evt = wr_en_i && (addr_i[3:2] == 2'b10);
    assign wr_ien = wr_en_i && (addr_i[3:2] == 2'b11);
    assign clr_r  = wr_evt ? data_i[WIDTH-1:0] : '0;
    assign clr_f  = wr_evt ? data_i[WIDTH+15:16] : '0;

    always_comb begin
        rise_d  = (rise_q & ~clr_r) | rise_set;
        fall_d  = (fall_q & ~clr_f) | fall_set;
        ien_r_d = wr_ien ? data_i[WIDTH-1:0] : ien_r_q;
        ien_f_d = wr_ien ? data_i[WIDTH+15:16] : ien_f_q;
    end

    always_comb begin
        event_w              = '0;
        event_w[WIDTH-1:0]   = rise_q;
        event_w[WIDTH+15:16] = fall_q;
        ien_w                = '0;
        ien_w[WIDTH-1:0]     = ien_r_q;
        ien_w[WIDTH+15:16]   = ien_f_q;
    end

    // Reads see pre-write register values, so read/write collisions return old data.
    always_comb begin
        data_d = data_q;
        if (rd_en_i) begin
            unique case (addr_i[3:2])
                2'b00: data_d = 32'(stable_q);
                2'b01: data_d = 32'(sync_q);
                2'b10: data_d = event_w;
                2'b11: data_d = ien_w;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            ien_r_q  <= '0;
            ien_f_q  <= '0;
            data_q   <= '0;
        end else begin
            meta_q   <= sw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            ien_r_q  <= ien_r_d;
            ien_f_q  <= ien_f_d;
            data_q   <= data_d;
        end
    end

    assign data_o = data_q;
    assign irq_o  = |((rise_q & ien_r_q) | (fall_q & ien_f_q));
endmodule

// File: tb/tb_switch_peripheral.sv
// Bench for switch_peripheral: register reads are checked by a scoreboard
// queue, steady-level transitions by a vector table, corners by hand.
module tb_switch_peripheral;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [7:0]  sw_i = '0;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_exp_t;
    rd_exp_t sb_q[$];
    logic    rd_pend = 1'b0;

    typedef struct {
        logic [7:0]  sw;
        logic [31:0] exp_state;
        logic [31:0] exp_event;
        string       name;
    } vec_t;
    vec_t vecs[3];

    switch_peripheral #(.WIDTH(8), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .rd_en_i(rd_en_i), .wr_en_i(wr_en_i),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .sw_i(sw_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= rd_en_i;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: read data with no expectation");
            end else begin
                rd_exp_t e;
                e = sb_q.pop_front();
                check(e.name, data_o, e.exp);
            end
        end
    end

    task automatic rd(logic [31:0] a, logic [31:0] exp, string name);
        rd_exp_t e;
        @(negedge clk);
        e.exp = exp;
        e.name = name;
        sb_q.push_back(e);
        rd_en_i = 1'b1;
        addr_i = a;
        @(negedge clk);
        rd_en_i = 1'b0;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        wr_en_i = 1'b1;
        addr_i = a;
        data_i = d;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive sw at a negedge and count edges until irq_o rises (bounded).
    task automatic irq_latency(logic [7:0] sw, string name);
        int n;
        @(negedge clk);
        sw_i = sw;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (irq_o) begin
                n = k;
                break;
            end
        end
        check(name, 32'(n), 32'(2 + D));
    endtask

    initial begin
        vecs[0] = '{8'h5A, 32'h5A, 32'h00A5_005A, "tbl_a5_to_5a"};
        vecs[1] = '{8'h0F, 32'h0F, 32'h0050_0005, "tbl_5a_to_0f"};
        vecs[2] = '{8'h00, 32'h00, 32'h000F_0000, "tbl_0f_to_00"};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 4; a++) rd(32'(a * 4), 32'h0, "reset_read");
        check("reset_irq", 32'(irq_o), 32'h0);

        wr(32'hC, 32'h0000_00FF);
        rd(32'hC, 32'h0000_00FF, "ien_readback");
        irq_latency(8'hA5, "state_latency_a5");
        rd(32'h0, 32'hA5, "state_a5");
        rd(32'h8, 32'h0000_00A5, "event_a5");
        rd(32'h4, 32'hA5, "raw_a5");
        wr(32'h0, 32'hFFFF_FFFF);
        rd(32'h0, 32'hA5, "state_write_ignored");
        wr(32'hC, 32'h0);
        wr(32'h8, 32'hFFFF_FFFF);

        foreach (vecs[i]) begin
            @(negedge clk);
            sw_i = vecs[i].sw;
            wait_cyc(40);
            rd(32'h0, vecs[i].exp_state, {vecs[i].name, "_state"});
            rd(32'h8, vecs[i].exp_event, {vecs[i].name, "_event"});
            wr(32'h8, 32'hFFFF_FFFF);
        end

        @(negedge clk);
        sw_i = 8'h01;
        wait_cyc(2);
        rd(32'h4, 32'h01, "glitch_raw");
        wait_cyc(7);
        sw_i = 8'h00;
        wait_cyc(30);
        rd(32'h0, 32'h0, "glitch_state");
        rd(32'h8, 32'h0, "glitch_event");

        @(negedge clk);
        sw_i = 8'h02;
        wait_cyc(D - 1);
        sw_i = 8'h00;
        wait_cyc(40);
        rd(32'h8, 32'h0, "pulse_short_rejected");

        @(negedge clk);
        sw_i = 8'h02;
        wait_cyc(D);
        sw_i = 8'h00;
        wait_cyc(40);
        rd(32'h8, 32'h0002_0002, "pulse_exact_accepted");
        wr(32'h8, 32'hFFFF_FFFF);

        @(negedge clk);
        sw_i = 8'h08;
        wait_cyc(40);
        sw_i = 8'h00;
        wait_cyc(40);
        rd(32'h8, 32'h0008_0008, "bit3_event");
        wr(32'h8, 32'h0000_0008);
        rd(32'h8, 32'h0008_0000, "bit3_w1c_rise");
        wr(32'h8, 32'hFFFF_FFFF);
        rd(32'h8, 32'h0, "bit3_w1c_all");

        @(negedge clk);
        sw_i = 8'h01;
        wait_cyc(40);
        wr(32'h8, 32'hFFFF_FFFF);
        wr(32'hC, 32'h0001_0000);
        check("irq_idle", 32'(irq_o), 32'h0);
        irq_latency(8'h00, "irq_fall_latency");
        @(negedge clk);
        check("irq_held", 32'(irq_o), 32'h1);
        wr_en_i = 1'b1;
        addr_i = 32'h8;
        data_i = 32'h0001_0000;
        @(posedge clk);
        #1;
        check("irq_cleared", 32'(irq_o), 32'h0);
        @(negedge clk);
        wr_en_i = 1'b0;

        wr(32'hC, 32'h0000_0004);
        @(negedge clk);
        sw_i = 8'h04;
        wait_cyc(2 + D - 1);
        wr_en_i = 1'b1;
        addr_i = 32'h8;
        data_i = 32'h0000_0004;
        @(negedge clk);
        wr_en_i = 1'b0;
        rd(32'h8, 32'h0000_0004, "set_beats_clear");
        check("collision_irq", 32'(irq_o), 32'h1);

        rd(32'h0, 32'h04, "pre_reset_state");
        @(negedge clk);
        sw_i = 8'h00;
        wait_cyc(8);
        #2;
        rst = 1'b1;
        #1;
        check("rst_irq_drop", 32'(irq_o), 32'h0);
        check("rst_data_o", data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(32'h0, 32'h0, "post_rst_state");
        rd(32'h8, 32'h0, "post_rst_event");
        rd(32'h4, 32'h0, "post_rst_raw");
        rd(32'hC, 32'h0, "post_rst_ien");

        wait_cyc(3);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
